// File: rtl/iecdrv_rom_arbiter.sv
// Shared-ROM fetch arbiter: on each ph2_f it snapshots every drive's address,
// issues the drives to the single ROM port in slot order, and steers each
// returned byte back into that drive's data register.

// One drive's fetched-byte register; it holds its value between rounds.
module iecdrv_rom_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] d,
  output logic [7:0] q
);
  // Capture the ROM byte when this lane's slot comes back.
  always_ff @(posedge clk) begin
    if (reset)   q <= 8'hFF;
    else if (we) q <= d;
  end
endmodule

module iecdrv_rom_arbiter #(
  parameter int NDRV   = 4,
  parameter int RD_LAT = 1,
  parameter int AW     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ph2_f,
  input  logic [NDRV*AW-1:0] drv_addr,
  input  logic [1:0]        rom_sz,
  input  logic              stdrom,
  input  logic [7:0]        rom_q,
  output logic [AW-1:0]     rom_addr,
  output logic [NDRV*8-1:0] drv_data,
  output logic              round_done,
  output logic              busy,
  output logic              overrun
);
  localparam int SW = (NDRV > 1) ? $clog2(NDRV) : 1;
  localparam logic [SW-1:0] LAST = SW'(NDRV - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state, state_nx;
  logic [SW-1:0]            slot, slot_nx;
  logic [NDRV-1:0][AW-1:0]  snap;
  logic [RD_LAT-1:0]        tag_vld;
  logic [RD_LAT-1:0][SW-1:0] tag_slot;
  logic                     issue, last_cap, abandon, cap;

  // Bank-select masking: bit 14 only exists in 32K mode, bit 13 in 16K/32K
  // mode or when the standard ROM is fitted; nothing above bit 14 is decoded.
  function automatic logic [AW-1:0] mask_addr(input logic [AW-1:0] a,
                                               input logic [1:0] sz,
                                               input logic std);
    logic [15:0] t;
    t     = 16'(a);
    t[15] = 1'b0;
    t[14] = t[14] & sz[1];
    t[13] = t[13] & (sz[0] | std);
    return t[AW-1:0];
  endfunction

  assign busy     = (state != IDLE);
  assign last_cap = tag_vld[RD_LAT-1] && (tag_slot[RD_LAT-1] == LAST);
  // A new strobe only counts as an overrun if it lands before the final
  // capture; landing on the final capture simply chains the next round.
  assign abandon  = ph2_f && busy && !last_cap;
  assign issue    = (state == ISSUE) && !ph2_f;
  assign cap      = tag_vld[RD_LAT-1] && !abandon;

  // Next-state: a strobe always (re)starts at slot 0; otherwise walk the slots.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    if (ph2_f) begin
      state_nx = ISSUE;
      slot_nx  = '0;
    end else begin
      case (state)
        ISSUE:   if (slot == LAST) state_nx = DRAIN;
                 else              slot_nx  = slot + SW'(1);
        DRAIN:   if (last_cap)     state_nx = IDLE;
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  // Snapshot, address issue, slot-tag pipeline and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap       <= '0;
      rom_addr   <= '0;
      tag_vld    <= '0;
      tag_slot   <= '0;
      round_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ph2_f)   snap    <= drv_addr;
      if (abandon) overrun <= 1'b1;
      if (issue)   rom_addr <= mask_addr(snap[slot], rom_sz, stdrom);
      round_done <= cap && last_cap;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tag_vld[i]  <= tag_vld[i-1] && !abandon;
        tag_slot[i] <= tag_slot[i-1];
      end
      tag_vld[0]  <= issue;
      tag_slot[0] <= slot;
    end
  end

  // Per-drive byte registers; only the returning slot's lane is written.
  for (genvar g = 0; g < NDRV; g++) begin : g_lane
    localparam logic [SW-1:0] IDX = SW'(g);
    iecdrv_rom_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (cap && (tag_slot[RD_LAT-1] == IDX)),
      .d     (rom_q),
      .q     (drv_data[g*8 +: 8])
    );
  end
endmodule

// File: tb/tb_iecdrv_rom_arbiter.sv
// Bench: two arbiter configurations share clock and stimulus; a round-level
// reference model predicts every output each cycle from start-cycle arithmetic.
module tb_iecdrv_rom_arbiter;
  localparam int NA = 4, LA = 1, WA = 15;
  localparam int NB = 8, LB = 3, WB = 16;

  logic clk = 1'b0, reset = 1'b1, ph2_f = 1'b0, stdrom = 1'b0;
  logic [1:0] rom_sz = 2'b11;
  logic [15:0] addr [8];
  logic [NA*WA-1:0] addr_a;
  logic [NB*WB-1:0] addr_b;
  logic [WA-1:0] raddr_a;
  logic [WB-1:0] raddr_b, p1 = '0, p2 = '0;
  logic [7:0] q_a, q_b;
  logic [NA*8-1:0] data_a;
  logic [NB*8-1:0] data_b;
  logic done_a, busy_a, ovr_a, done_b, busy_b, ovr_b;
  int n_cmp = 0, n_err = 0, cyc = 0;

  // model state, index 0 = config A, 1 = config B
  bit          m_act [2], m_ovr [2], m_done [2], m_busy [2];
  int          m_s [2];
  logic [15:0] m_snap [2][8], m_ea [2][8], m_rom [2];
  logic [7:0]  m_dat [2][8];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NA; i++) addr_a[i*WA +: WA] = addr[i][WA-1:0];
    for (int i = 0; i < NB; i++) addr_b[i*WB +: WB] = addr[i];
  end

  function automatic logic [7:0] rom_val(input int d, input logic [15:0] a);
    return (d == 0) ? a[7:0] : a[7:0] + a[15:8];
  endfunction

  // ROM A answers in the capture cycle; ROM B adds two address stages.
  assign q_a = raddr_a[7:0];
  always @(posedge clk) begin
    p1 <= raddr_b;
    p2 <= p1;
  end
  assign q_b = rom_val(1, p2);

  iecdrv_rom_arbiter #(.NDRV(NA), .RD_LAT(LA), .AW(WA)) u_a (
    .clk(clk), .reset(reset), .ph2_f(ph2_f), .drv_addr(addr_a), .rom_sz(rom_sz),
    .stdrom(stdrom), .rom_q(q_a), .rom_addr(raddr_a), .drv_data(data_a),
    .round_done(done_a), .busy(busy_a), .overrun(ovr_a));

  iecdrv_rom_arbiter #(.NDRV(NB), .RD_LAT(LB), .AW(WB)) u_b (
    .clk(clk), .reset(reset), .ph2_f(ph2_f), .drv_addr(addr_b), .rom_sz(rom_sz),
    .stdrom(stdrom), .rom_q(q_b), .rom_addr(raddr_b), .drv_data(data_b),
    .round_done(done_b), .busy(busy_b), .overrun(ovr_b));

  function automatic logic [15:0] mask(input logic [15:0] a, input logic [1:0] sz, input logic sr);
    logic [15:0] r;
    r     = a;
    r[15] = 1'b0;
    r[14] = a[14] & sz[1];
    r[13] = a[13] & (sz[0] | sr);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Round started in cycle s: slot k issued in s+1+k, captured at the end of
  // s+1+k+L, done visible the cycle after the last capture.
  task automatic model_edge(input int d);
    int n, l, k, kc;
    bit ab;
    n = (d == 0) ? NA : NB;
    l = (d == 0) ? LA : LB;
    m_done[d] = 1'b0;
    if (reset) begin
      m_act[d] = 1'b0; m_ovr[d] = 1'b0; m_busy[d] = 1'b0; m_rom[d] = '0;
      for (int i = 0; i < 8; i++) m_dat[d][i] = 8'hFF;
      return;
    end
    ab = ph2_f && m_act[d] && (cyc >= m_s[d] + 1) && (cyc <= m_s[d] + n + l - 1);
    if (m_act[d] && !ab) begin
      k = cyc - m_s[d] - 1;
      if (k >= 0 && k < n) begin
        m_ea[d][k] = mask(m_snap[d][k], rom_sz, stdrom);
        m_rom[d]   = m_ea[d][k];
      end
      kc = k - l;
      if (kc >= 0 && kc < n) begin
        m_dat[d][kc] = rom_val(d, m_ea[d][kc]);
        if (kc == n - 1) begin m_done[d] = 1'b1; m_act[d] = 1'b0; end
      end
    end
    if (ab) m_ovr[d] = 1'b1;
    if (ph2_f) begin
      m_act[d] = 1'b1;
      m_s[d]   = cyc;
      for (int i = 0; i < 8; i++) m_snap[d][i] = (d == 0) ? {1'b0, addr[i][14:0]} : addr[i];
    end
    m_busy[d] = m_act[d];
  endtask

  task automatic check_all();
    logic [31:0] ea;
    logic [63:0] eb;
    for (int i = 0; i < NA; i++) ea[i*8 +: 8] = m_dat[0][i];
    for (int i = 0; i < NB; i++) eb[i*8 +: 8] = m_dat[1][i];
    chk($sformatf("a.data@%0d", cyc), 64'(data_a),  64'(ea));
    chk($sformatf("a.busy@%0d", cyc), 64'(busy_a),  64'(m_busy[0]));
    chk($sformatf("a.done@%0d", cyc), 64'(done_a),  64'(m_done[0]));
    chk($sformatf("a.ovr@%0d",  cyc), 64'(ovr_a),   64'(m_ovr[0]));
    chk($sformatf("a.addr@%0d", cyc), 64'(raddr_a), 64'(m_rom[0]));
    chk($sformatf("b.data@%0d", cyc), 64'(data_b),  eb);
    chk($sformatf("b.busy@%0d", cyc), 64'(busy_b),  64'(m_busy[1]));
    chk($sformatf("b.done@%0d", cyc), 64'(done_b),  64'(m_done[1]));
    chk($sformatf("b.ovr@%0d",  cyc), 64'(ovr_b),   64'(m_ovr[1]));
    chk($sformatf("b.addr@%0d", cyc), 64'(raddr_b), 64'(m_rom[1]));
  endtask

  task automatic tick(input logic p);
    ph2_f = p;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cyc++;
    ph2_f = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0);
  endtask

  int ph_c, lat_a, lat_b, nd_a, nd_b;
  logic [15:0] set2 [4];
  logic [31:0] e32;
  logic [1:0] sz_tab [3];

  initial begin
    sz_tab[0] = 2'b00; sz_tab[1] = 2'b01; sz_tab[2] = 2'b11;
    for (int i = 0; i < 8; i++) addr[i] = '0;

    // reset, with a strobe that must be ignored
    reset = 1'b1; tick(1'b0); tick(1'b1); tick(1'b0);
    chk("rst.data_a", 64'(data_a), 64'(32'hFFFF_FFFF));
    chk("rst.busy_a", 64'(busy_a), 64'd0);
    chk("rst.addr_b", 64'(raddr_b), 64'd0);
    reset = 1'b0; idle(2);

    // basic round; addresses change after the snapshot
    rom_sz = 2'b11; stdrom = 1'b0;
    addr[0] = 16'h1234; addr[1] = 16'h5678; addr[2] = 16'h7ABC; addr[3] = 16'h0001;
    for (int i = 4; i < 8; i++) addr[i] = 16'($urandom);
    ph_c = cyc; tick(1'b1);
    for (int i = 0; i < 8; i++) addr[i] = 16'($urandom);
    lat_a = -1; lat_b = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (done_a && lat_a < 0) lat_a = cyc - ph_c;
      if (done_b && lat_b < 0) lat_b = cyc - ph_c;
    end
    chk("lat_a", 64'(lat_a), 64'd6);
    chk("lat_b", 64'(lat_b), 64'd12);
    chk("basic.data_a", 64'(data_a), 64'(32'h01BC_7834));

    // address masking, plus a mid-round size change
    rom_sz = 2'b00; stdrom = 1'b0; addr[0] = 16'h7FFF; addr[1] = 16'hFFFF;
    tick(1'b1); tick(1'b0);
    chk("mask8k_a", 64'(raddr_a), 64'h1FFF);
    chk("mask8k_b", 64'(raddr_b), 64'h1FFF);
    rom_sz = 2'b11; idle(14);
    rom_sz = 2'b00; stdrom = 1'b1;
    tick(1'b1); tick(1'b0);
    chk("maskstd_a", 64'(raddr_a), 64'h3FFF);
    chk("maskstd_b", 64'(raddr_b), 64'h3FFF);
    idle(14);

    // overrun: second strobe two cycles after the first
    rom_sz = 2'b11; stdrom = 1'b0;
    for (int i = 0; i < 4; i++) set2[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) addr[i] = (i < 4) ? (set2[i] ^ 16'h00A5) : 16'($urandom);
    tick(1'b1); tick(1'b0);
    for (int i = 0; i < 4; i++) addr[i] = set2[i];
    tick(1'b1);
    nd_a = 0;
    for (int i = 0; i < 20; i++) begin tick(1'b0); nd_a += int'(done_a); end
    for (int i = 0; i < 4; i++) e32[i*8 +: 8] = set2[i][7:0];
    chk("ovr.flag_a", 64'(ovr_a), 64'd1);
    chk("ovr.ndone_a", 64'(nd_a), 64'd1);
    chk("ovr.data_a", 64'(data_a), 64'(e32));

    // strobe landing on the final capture of A chains without overrun
    reset = 1'b1; tick(1'b0); reset = 1'b0; tick(1'b0);
    nd_a = 0; nd_b = 0;
    tick(1'b1); nd_a += int'(done_a);
    for (int i = 0; i < 4; i++) begin tick(1'b0); nd_a += int'(done_a); end
    for (int i = 0; i < 4; i++) addr[i] = 16'($urandom);
    tick(1'b1); nd_a += int'(done_a); nd_b += int'(done_b);
    for (int i = 0; i < 20; i++) begin tick(1'b0); nd_a += int'(done_a); nd_b += int'(done_b); end
    chk("chain.ndone_a", 64'(nd_a), 64'd2);
    chk("chain.ovr_a", 64'(ovr_a), 64'd0);
    chk("chain.ovr_b", 64'(ovr_b), 64'd1);
    chk("chain.ndone_b", 64'(nd_b), 64'd1);

    // reset in cycle 3 of a round, then a normal round
    reset = 1'b1; tick(1'b0); reset = 1'b0; tick(1'b0);
    tick(1'b1); tick(1'b0); tick(1'b0);
    reset = 1'b1; tick(1'b0); reset = 1'b0;
    chk("rstmid.data_a", 64'(data_a), 64'(32'hFFFF_FFFF));
    chk("rstmid.busy_b", 64'(busy_b), 64'd0);
    nd_a = 0;
    for (int i = 0; i < 15; i++) begin tick(1'b0); nd_a += int'(done_a) + int'(done_b); end
    chk("rstmid.ndone", 64'(nd_a), 64'd0);
    for (int i = 0; i < 4; i++) set2[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) addr[i] = set2[i];
    tick(1'b1);
    nd_a = 0;
    for (int i = 0; i < 20; i++) begin tick(1'b0); nd_a += int'(done_a); end
    for (int i = 0; i < 4; i++) e32[i*8 +: 8] = set2[i][7:0];
    chk("rstmid.next_ndone", 64'(nd_a), 64'd1);
    chk("rstmid.next_data", 64'(data_a), 64'(e32));

    // randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) addr[i] = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rom_sz = sz_tab[$urandom_range(0, 2)];
      if ($urandom_range(0, 7) == 0) stdrom = 1'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      tick(($urandom_range(0, 8) == 0) ? 1'b1 : 1'b0);
    end
    reset = 1'b0;
    idle(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
